// File: rtl/wb_write_arbiter_if.sv
// wb_write_arbiter_if
//   Bundles the writeback-side signals of wb_write_arbiter: the in-order
//   pipeline WB request, long-unit issue notification, the long-unit result
//   valid/ready handshake, the registered register-file write port, the busy
//   scoreboard and the hold request toward the hazard unit.
//   master : the surrounding core (drives requests, observes RF write/status)
//   slave  : the arbiter
`timescale 1ns/1ps
interface wb_write_arbiter_if;
    logic        pipe_wen;
    logic [4:0]  pipe_rd_addr;
    logic [31:0] pipe_rd_data;
    logic        lu_issue_valid;
    logic [4:0]  lu_issue_rd;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_rd_addr;
    logic [31:0] lu_rd_data;
    logic        rf_wen;
    logic [4:0]  rf_rd_addr;
    logic [31:0] rf_rd_data;
    logic [31:0] busy_mask;
    logic        wb_hold;

    modport master (
        output pipe_wen, pipe_rd_addr, pipe_rd_data,
        output lu_issue_valid, lu_issue_rd,
        output lu_valid, lu_rd_addr, lu_rd_data,
        input  lu_ready,
        input  rf_wen, rf_rd_addr, rf_rd_data,
        input  busy_mask, wb_hold
    );

    modport slave (
        input  pipe_wen, pipe_rd_addr, pipe_rd_data,
        input  lu_issue_valid, lu_issue_rd,
        input  lu_valid, lu_rd_addr, lu_rd_data,
        output lu_ready,
        output rf_wen, rf_rd_addr, rf_rd_data,
        output busy_mask, wb_hold
    );
endinterface

// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter
//   Owns the register-file write port. The pipeline WB stage has fixed
//   priority; long-unit (mul/div) results are buffered in a small FIFO and
//   drained whenever the pipeline leaves the slot free. A per-register busy
//   scoreboard tracks long-unit results still in flight, and a starvation
//   counter raises wb_hold when the FIFO has waited too long.
// Ports:
//   clk  : system clock, all state on posedge
//   rst  : asynchronous active-high reset
//   bus  : wb_write_arbiter_if.slave (pipeline WB request, long-unit issue and
//          result handshake, registered rf_* write port, busy_mask, wb_hold)
// Parameters:
//   DEPTH        : long-unit result FIFO entries (power of two, >= 2)
//   STARVE_LIMIT : unserved cycles of a non-empty FIFO before wb_hold rises
`timescale 1ns/1ps
module wb_write_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    wb_write_arbiter_if.slave bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [STV_W-1:0] LIMIT_C = STV_W'(STARVE_LIMIT);

    logic [4:0]       fifo_addr [DEPTH];
    logic [31:0]      fifo_data [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [STV_W-1:0] starve_cnt;

    logic        rf_wen_q;
    logic [4:0]  rf_addr_q;
    logic [31:0] rf_data_q;
    logic [31:0] busy_q;

    logic        accept;
    logic        push;
    logic        drop;
    logic        pipe_sel;
    logic        pop;
    logic [4:0]  head_addr;
    logic [31:0] head_data;
    logic [31:0] set_mask;
    logic [31:0] clr_mask;
    logic [31:0] busy_next;

    // Ready depends only on occupancy so it never combinationally loops
    // through the same-cycle pop decision.
    assign bus.lu_ready = (count < DEPTH_C);

    assign accept   = bus.lu_valid && bus.lu_ready;
    assign push     = accept && (bus.lu_rd_addr != 5'd0);
    assign drop     = accept && (bus.lu_rd_addr == 5'd0);
    // A pipeline write to x0 is a no-op and leaves the slot to the FIFO.
    assign pipe_sel = bus.pipe_wen && (bus.pipe_rd_addr != 5'd0);
    // Only entries present at the start of the cycle can pop (no fall-through).
    assign pop      = !pipe_sel && (count != '0);

    assign head_addr = fifo_addr[rd_ptr];
    assign head_data = fifo_data[rd_ptr];

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (bus.lu_issue_valid) set_mask[bus.lu_issue_rd] = 1'b1;
        if (pop)                clr_mask[head_addr]       = 1'b1;
        if (drop)               clr_mask[bus.lu_rd_addr]  = 1'b1;
    end

    // Set is ORed in after the clear so a same-cycle reissue keeps the bit.
    assign busy_next = ((busy_q & ~clr_mask) | set_mask) & ~32'h1;

    assign bus.rf_wen     = rf_wen_q;
    assign bus.rf_rd_addr = rf_addr_q;
    assign bus.rf_rd_data = rf_data_q;
    assign bus.busy_mask  = busy_q;
    assign bus.wb_hold    = (starve_cnt == LIMIT_C);

    // FIFO storage is pure data; validity is carried by count and pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= bus.lu_rd_addr;
            fifo_data[wr_ptr] <= bus.lu_rd_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
            busy_q     <= '0;
            rf_wen_q   <= 1'b0;
            rf_addr_q  <= '0;
            rf_data_q  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            if ((count == '0) || pop)
                starve_cnt <= '0;
            else if (starve_cnt != LIMIT_C)
                starve_cnt <= starve_cnt + STV_W'(1);

            busy_q <= busy_next;

            // Write port stage: pipeline first, FIFO head second, else idle
            // with address/data held.
            if (pipe_sel) begin
                rf_wen_q  <= 1'b1;
                rf_addr_q <= bus.pipe_rd_addr;
                rf_data_q <= bus.pipe_rd_data;
            end else if (pop) begin
                rf_wen_q  <= 1'b1;
                rf_addr_q <= head_addr;
                rf_data_q <= head_data;
            end else begin
                rf_wen_q  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_wb_write_arbiter.sv
// tb_wb_write_arbiter
//   Directed bench for wb_write_arbiter (DEPTH=2, STARVE_LIMIT=4). The driver
//   queues each register-file write it expects; a monitor on the falling edge
//   pops and compares whenever rf_wen is high. Status outputs are checked
//   inline by the driver.
`timescale 1ns/1ps
module tb_wb_write_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   failures;
    logic [36:0] exp_q [$];

    wb_write_arbiter_if bus ();

    wb_write_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic idle();
        bus.pipe_wen       = 1'b0;
        bus.pipe_rd_addr   = '0;
        bus.pipe_rd_data   = '0;
        bus.lu_issue_valid = 1'b0;
        bus.lu_issue_rd    = '0;
        bus.lu_valid       = 1'b0;
        bus.lu_rd_addr     = '0;
        bus.lu_rd_data     = '0;
    endtask

    task automatic pipe(input logic [4:0] a, input logic [31:0] d);
        bus.pipe_wen     = 1'b1;
        bus.pipe_rd_addr = a;
        bus.pipe_rd_data = d;
    endtask

    task automatic lu(input logic [4:0] a, input logic [31:0] d);
        bus.lu_valid   = 1'b1;
        bus.lu_rd_addr = a;
        bus.lu_rd_data = d;
    endtask

    // Monitor: every RF write must match the oldest outstanding expectation.
    initial begin
        logic [36:0] e;
        forever begin
            @(negedge clk);
            if (bus.rf_wen === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 32'(bus.rf_wen), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 32'(bus.rf_rd_addr), 32'(e[36:32]));
                    chk("wr_data", bus.rf_rd_data, e[31:0]);
                end
            end
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        idle();
        rst = 1'b1;
        #3;
        chk("rst_rf_wen",   32'(bus.rf_wen),   32'd0);
        chk("rst_rf_addr",  32'(bus.rf_rd_addr), 32'd0);
        chk("rst_rf_data",  bus.rf_rd_data,    32'd0);
        chk("rst_busy",     bus.busy_mask,     32'd0);
        chk("rst_lu_ready", 32'(bus.lu_ready), 32'd1);
        chk("rst_wb_hold",  32'(bus.wb_hold),  32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Pipeline only
        pipe(5'd5, 32'hDEADBEEF);
        expect_wr(5'd5, 32'hDEADBEEF);
        step();
        chk("pipe_wen",  32'(bus.rf_wen),     32'd1);
        chk("pipe_addr", 32'(bus.rf_rd_addr), 32'd5);
        chk("pipe_data", bus.rf_rd_data,      32'hDEADBEEF);
        pipe(5'd0, 32'h11111111);
        step();
        chk("pipe_x0_wen", 32'(bus.rf_wen), 32'd0);
        idle();
        step();

        // Long-unit path and scoreboard
        bus.lu_issue_valid = 1'b1;
        bus.lu_issue_rd    = 5'd7;
        step();
        idle();
        chk("issue7_busy", bus.busy_mask, 32'h80);
        lu(5'd7, 32'h12345678);
        chk("lu7_ready", 32'(bus.lu_ready), 32'd1);
        step();
        idle();
        chk("lu7_no_fallthrough", 32'(bus.rf_wen), 32'd0);
        chk("lu7_busy_held", bus.busy_mask, 32'h80);
        expect_wr(5'd7, 32'h12345678);
        step();
        chk("lu7_wen", 32'(bus.rf_wen), 32'd1);
        chk("lu7_busy_clear", bus.busy_mask, 32'h0);

        // Contention, full FIFO and starvation
        pipe(5'd10, 32'h100); expect_wr(5'd10, 32'h100);
        lu(5'd3, 32'hA);
        step();
        chk("cont_ready_1", 32'(bus.lu_ready), 32'd1);
        pipe(5'd11, 32'h101); expect_wr(5'd11, 32'h101);
        lu(5'd4, 32'hB);
        step();
        chk("cont_ready_full", 32'(bus.lu_ready), 32'd0);
        chk("cont_hold_1", 32'(bus.wb_hold), 32'd0);
        pipe(5'd12, 32'h102); expect_wr(5'd12, 32'h102);
        lu(5'd5, 32'hC);
        step();
        chk("cont_ready_wait", 32'(bus.lu_ready), 32'd0);
        pipe(5'd13, 32'h103); expect_wr(5'd13, 32'h103);
        step();
        chk("starve_hold_3", 32'(bus.wb_hold), 32'd0);
        pipe(5'd14, 32'h104); expect_wr(5'd14, 32'h104);
        step();
        chk("starve_hold_4", 32'(bus.wb_hold), 32'd1);
        pipe(5'd15, 32'h105); expect_wr(5'd15, 32'h105);
        step();
        chk("hold_pipe_wins", 32'(bus.rf_rd_addr), 32'd15);
        chk("starve_hold_sat", 32'(bus.wb_hold), 32'd1);
        bus.pipe_wen = 1'b0;
        expect_wr(5'd3, 32'hA);
        step();
        chk("pop_hold_clear", 32'(bus.wb_hold), 32'd0);
        chk("pop_ready", 32'(bus.lu_ready), 32'd1);
        expect_wr(5'd4, 32'hB);
        step();
        idle();
        chk("third_accepted_ready", 32'(bus.lu_ready), 32'd1);
        expect_wr(5'd5, 32'hC);
        step();
        chk("fifo_drained_ready", 32'(bus.lu_ready), 32'd1);

        // Result to x0 is dropped
        lu(5'd0, 32'h55);
        chk("x0_ready_before", 32'(bus.lu_ready), 32'd1);
        step();
        idle();
        chk("x0_ready_after", 32'(bus.lu_ready), 32'd1);
        chk("x0_no_write_1", 32'(bus.rf_wen), 32'd0);
        step();
        chk("x0_no_write_2", 32'(bus.rf_wen), 32'd0);

        // Reissue to rd=9 on the cycle its pop emits rd=9
        bus.lu_issue_valid = 1'b1;
        bus.lu_issue_rd    = 5'd9;
        step();
        idle();
        pipe(5'd20, 32'h200); expect_wr(5'd20, 32'h200);
        lu(5'd9, 32'h99);
        step();
        idle();
        bus.lu_issue_valid = 1'b1;
        bus.lu_issue_rd    = 5'd9;
        expect_wr(5'd9, 32'h99);
        step();
        idle();
        chk("set_wins_busy", bus.busy_mask, 32'h200);
        lu(5'd9, 32'h9A);
        step();
        idle();
        expect_wr(5'd9, 32'h9A);
        step();
        chk("busy9_cleared", bus.busy_mask, 32'h0);

        // Reset mid-stream with two buffered results
        bus.lu_issue_valid = 1'b1;
        bus.lu_issue_rd    = 5'd4;
        step();
        bus.lu_issue_rd    = 5'd5;
        step();
        idle();
        pipe(5'd21, 32'h21); expect_wr(5'd21, 32'h21);
        lu(5'd4, 32'h44);
        step();
        pipe(5'd22, 32'h22); expect_wr(5'd22, 32'h22);
        lu(5'd5, 32'h55);
        step();
        bus.lu_valid = 1'b0;
        chk("mid_full", 32'(bus.lu_ready), 32'd0);
        pipe(5'd23, 32'h23); expect_wr(5'd23, 32'h23);
        step();
        chk("mid_busy", bus.busy_mask, 32'h30);
        @(negedge clk);
        #1;
        rst = 1'b1;
        idle();
        #1;
        chk("mid_rst_wen",   32'(bus.rf_wen),   32'd0);
        chk("mid_rst_busy",  bus.busy_mask,     32'd0);
        chk("mid_rst_ready", 32'(bus.lu_ready), 32'd1);
        chk("mid_rst_hold",  32'(bus.wb_hold),  32'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_no_write", 32'(bus.rf_wen), 32'd0);
            chk("post_rst_ready", 32'(bus.lu_ready), 32'd1);
        end

        step();
        chk("pending_expected", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Owns the register-file write port (rf_wen / rf_rd_addr / rf_rd_data). Merges two writeback sources into it:
  - the in-order pipeline WB stage, which has fixed priority and no backpressure;
  - the long-latency M-extension unit (multiplier/divider), which uses a valid/ready handshake and a small result FIFO.
- Keeps a per-register busy scoreboard so decode can stall on registers whose long-unit result is still pending.

Parameters:
- DEPTH, 2: long-unit result FIFO entries (power of two, ≥2).
- STARVE_LIMIT, 4: consecutive cycles a non-empty FIFO may go unserved before wb_hold is raised.

Ports:
- clk  input  1  system clock, all state on posedge
- rst  input  1  reset; one clock; reset is asynchronous and active-high
- pipe_wen  input  1  pipeline WB write request
- pipe_rd_addr  input  5  pipeline destination register
- pipe_rd_data  input  32  pipeline write data
- lu_issue_valid  input  1  long-unit op issued this cycle
- lu_issue_rd  input  5  destination of the issued op
- lu_valid  input  1  long-unit result valid
- lu_ready  output  1  arbiter can accept a long-unit result
- lu_rd_addr  input  5  long-unit result destination
- lu_rd_data  input  32  long-unit result data
- rf_wen  output  1  register-file write enable (registered)
- rf_rd_addr  output  5  register-file write address (registered)
- rf_rd_data  output  32  register-file write data (registered)
- busy_mask  output  32  bit i=1: long-unit result for xi not yet written
- wb_hold  output  1  request to hazard unit to bubble the pipeline WB slot

Behaviour:
- Reset (async, while rst=1): rf_wen=0, rf_rd_addr=0, rf_rd_data=0, busy_mask=0, FIFO empty (count=0), starve counter=0. Consequently lu_ready=1 and wb_hold=0. Any buffered results are discarded mid-operation.
- lu_ready = (count < DEPTH). It is combinational from count only, and does not depend on same-cycle pops.
- Accept: lu_valid && lu_ready at a posedge.
  - lu_rd_addr != 0: push {addr, data} to the FIFO tail.
  - lu_rd_addr == 0: handshake completes, but the result is dropped and never enters the FIFO.
- Selection, evaluated each cycle, with the result registered at the next posedge (1-cycle latency):
  1. pipe_wen && pipe_rd_addr != 0: rf_* <= pipe values, rf_wen <= 1; FIFO does not pop.
  2. else if count > 0: pop the FIFO head; rf_* <= head, rf_wen <= 1.
  3. else rf_wen <= 0; rf_rd_addr and rf_rd_data hold their previous values.
- A pipeline write to x0 frees the slot, so the FIFO may pop in that cycle.
- Push and pop in the same cycle: count unchanged. A push to an empty FIFO is not poppable until the next cycle; there is no fall-through.
- FIFO order is strict FIFO. Pointers wrap modulo DEPTH.
- Scoreboard:
  - Set bit r on lu_issue_valid && lu_issue_rd == r, r != 0.
  - Clear bit r when a FIFO pop emits address r.
  - Clear bit r when an accepted result to r is dropped; only x0 results are dropped, and bit 0 is never set.
  - Same-cycle set and clear of the same bit: set wins.
  - Bit 0 is always 0.
- Upstream guarantees:
  - no second issue to a register whose busy bit is set;
  - no pipeline write to a busy register.
- The arbiter does not check the upstream guarantees and does not reorder or suppress writes.
- Starvation:
  - The counter increments each cycle that count > 0 and no pop occurs, saturating at STARVE_LIMIT.
  - The counter clears on any pop or when count == 0.
  - wb_hold = (counter == STARVE_LIMIT), combinational.
  - If pipe_wen arrives anyway while wb_hold=1, the pipeline still wins.

Test Plan:
- Reset mid-stream:
  - Stimulus: FIFO holds 2 entries and busy_mask=0x0000_0030; assert rst between clock edges.
  - Response: outputs clear immediately (rf_wen=0, busy_mask=0, lu_ready=1, wb_hold=0). After release, no stale write appears.
- Pipeline only:
  - Stimulus: pipe_wen=1, addr=5, data=0xDEADBEEF at edge N.
  - Response: at edge N+1, rf_wen=1, rf_rd_addr=5, rf_rd_data=0xDEADBEEF.
  - Stimulus: pipe_wen=1 with addr=0.
  - Response: rf_wen=0 at the next edge.
- Long-unit path and scoreboard:
  - Stimulus: issue rd=7 (busy_mask=0x80), then lu result {7, 0x12345678} accepted with the pipeline idle.
  - Response: the result is written one cycle after the accept edge, and busy_mask returns to 0 on the same edge as the write.
- Contention and full FIFO (DEPTH=2):
  - Stimulus: pipe writes every cycle; lu pushes {3, 0xA}, {4, 0xB}, then offers {5, 0xC}.
  - Response:
    - lu_ready drops to 0 after 2 accepts, and the third result waits.
    - Once the pipeline goes idle, x3=0xA then x4=0xB are written on consecutive cycles.
    - The third result is then accepted.
- Starvation:
  - Stimulus: FIFO non-empty while pipe_wen=1 (addr≠0) for 4 cycles.
  - Response: wb_hold=1 from the 4th cycle. With pipe_wen=0 the next cycle, a pop occurs and wb_hold returns to 0.
- Corner cases:
  - Stimulus: lu result to x0.
  - Response: accepted (lu_ready unaffected), no write, count unchanged.
  - Stimulus: issue to rd=9 in the same cycle that a pop emits rd=9.
  - Response: bit 9 remains set.
